jtag_host: RTL and testbench
============================

Name: jtag_host

Overview:
JTAG initiator driving the TCK/TMS/TDI pins of the on-chip `tap` and sampling TDO. It replaces the hand-built TMS bit-sequence benches with a command interface: reset, shift IR, shift DR, or run N idle cycles. It tracks the TAP state internally and always parks in Run-Test/Idle. It sits between a debug/BIST sequencer (command side) and the TAP pins.

Parameters:
DATA_W, 64, max shift length and width of command/response data
LEN_W, 7, width of cmd_len; must hold DATA_W
TCK_HALF, 1, clk cycles per TCK half-period (>=1); 1 gives TCK = clk/2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  host idle in RTI and able to accept a command
cmd_op  in  2  opcode, jtag_host_pkg::op_e
cmd_len  in  LEN_W  shift bit count, or idle TCK count
cmd_data  in  DATA_W  TDI data, bit 0 shifted first
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_W  captured TDO, bit 0 = first TDO bit, bits >= len are zero
rsp_err  out  1  qualifies rsp_valid: illegal length
tck  out  1  JTAG clock
tms  out  1  JTAG mode select
tdi  out  1  JTAG data to TAP
tdo  in  1  JTAG data from TAP

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0. FSM enters AUTO_TLR.
- TCK timing:
  - tck toggles every TCK_HALF clk cycles only while busy. It rests low in IDLE/DONE.
  - tms/tdi update on the clk edge that drives tck low (fall strobe).
  - tdo is sampled on the clk edge that drives tck high (rise strobe).
  - One slot = one full TCK period.
- Handshake:
  - Command is accepted on cmd_valid && cmd_ready. cmd_ready is high only in IDLE.
  - Command fields are registered at accept.
  - rsp_valid pulses once and has no backpressure. rsp_data/rsp_err hold until the next accept.
- FSM states: AUTO_TLR, IDLE, PRE, SHIFT, POST, RUN, DONE.
  - AUTO_TLR (after reset and for op RESET): 6 slots, TMS = 1,1,1,1,1,0, ending in RTI.
    - After reset it goes to IDLE with no rsp.
    - For op RESET it goes to DONE.
  - PRE: the TMS prefix from RTI.
    - SHIFT_DR: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
    - SHIFT_IR: 1,1,0,0.
  - SHIFT: cmd_len slots.
    - tdi = data[i].
    - TMS = 0, except TMS = 1 on the last slot (Exit1).
    - TDO is sampled at each rise into capture bit i.
  - POST: TMS = 1 (Update), then 0 (RTI).
  - RUN (op IDLE): cmd_len slots with TMS = 0. cmd_len = 0 goes straight to DONE.
  - DONE: rsp_valid = 1 for one clk, then IDLE.
- Total slots: SHIFT_DR = len + 5, SHIFT_IR = len + 6, RESET = 6, IDLE = len.
- Error case:
  - Trigger: SHIFT_IR/DR with cmd_len == 0 or cmd_len > DATA_W.
  - Response: no TCK edges, DONE on the clk after accept, rsp_err=1, rsp_data=0.
- Outside SHIFT, tdi = 0.
- Mid-operation reset:
  - All outputs immediately take their reset values.
  - The FSM re-runs AUTO_TLR after release.
  - The in-flight command is dropped with no rsp.
- cmd_valid is ignored while cmd_ready = 0.

Decomposition:
- jtag_host_pkg holds:
  - op_e: RESET=2'b00, SHIFT_IR=2'b01, SHIFT_DR=2'b10, IDLE=2'b11.
  - state_e.
  - TMS prefix constants.
  - TLR_SLOTS = 6.
- Sub-module jtag_tck_gen (TCK_HALF counter) outputs tck, fall_stb and rise_stb, gated by enable. The strobes start with a fall strobe so that tms is set up before the first rise.

Test Plan:
- Reset release:
  - Stimulus: release rst; bench TAP model tracks state.
  - Required: exactly 6 rising tck edges with TMS 1,1,1,1,1,0; then cmd_ready=1, model in RTI, tck low.
- SHIFT_IR (IDCODE load):
  - Stimulus: SHIFT_IR len=4 data=4'b0010.
  - Required: 10 slots; TMS 1,1,0,0,0,0,0,1,1,0; TDI during shift 0,1,0,0.
  - Required: rsp_data=4'b0001 (IR capture value), rsp_err=0.
- SHIFT_DR (IDCODE read):
  - Stimulus: SHIFT_DR len=32 data=0.
  - Required: rsp_data[31:0] equals the model IDCODE 32'h1000_0001; bits 63:32 = 0; 37 slots.
- BYPASS loopback:
  - Stimulus: tdo = tdi delayed one TCK; SHIFT_DR len=8 data=8'hA5.
  - Required: rsp_data=8'h4A.
- IDLE and error cases:
  - Stimulus: IDLE len=100.
  - Required: 100 rising edges, TMS=0 throughout, then rsp_valid.
  - Stimulus: SHIFT_DR len=0, then len=65.
  - Required: each gives rsp_valid with rsp_err=1 one clk after accept and zero tck edges.
- Reset mid-shift:
  - Stimulus: assert rst at slot 10 of a len=32 SHIFT_DR.
  - Required: tck=0, tms=1 the same cycle; no rsp_valid; after release, AUTO_TLR re-runs and cmd_ready returns after 6 slots.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared opcodes, FSM states and TAP TMS sequences for jtag_host.
package jtag_host_pkg;

   typedef enum logic [1:0] {
      OP_RESET    = 2'b00,
      OP_SHIFT_IR = 2'b01,
      OP_SHIFT_DR = 2'b10,
      OP_IDLE     = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_AUTO_TLR,
      S_IDLE,
      S_PRE,
      S_SHIFT,
      S_POST,
      S_RUN,
      S_DONE
   } state_e;

   // TMS sequences are stored LSB first: bit n is the TMS of slot n.
   localparam int         TLR_SLOTS    = 6;
   localparam logic [5:0] TLR_TMS      = 6'b011111;
   localparam int         PRE_IR_SLOTS = 4;
   localparam logic [3:0] PRE_IR_TMS   = 4'b0011;
   localparam int         PRE_DR_SLOTS = 3;
   localparam logic [2:0] PRE_DR_TMS   = 3'b001;
   localparam int         POST_SLOTS   = 2;

endpackage

// File: rtl/jtag_host_tck_gen.sv
// rtl/jtag_host_tck_gen.sv - TCK divider; the first strobe after enable is always a fall strobe.
module jtag_tck_gen #(
   parameter int TCK_HALF = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_tck,
   output logic o_fall_stb,
   output logic o_rise_stb
);
   localparam int CNT_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_ph;
   logic             w_tick;

   assign w_tick     = i_en && (r_cnt == '0);
   assign o_fall_stb = w_tick && !r_ph;
   assign o_rise_stb = w_tick && r_ph;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_ph  <= 1'b0;
         o_tck <= 1'b0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_ph  <= 1'b0;
         o_tck <= 1'b0;
      end else begin
         r_cnt <= (r_cnt == CNT_W'(TCK_HALF - 1)) ? '0 : r_cnt + 1'b1;
         if (w_tick) begin
            o_tck <= r_ph;
            r_ph  <= !r_ph;
         end
      end
   end
endmodule

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG initiator: turns reset/shift/idle commands into TCK/TMS/TDI slots.
module jtag_host
   import jtag_host_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int LEN_W    = 7,
   parameter int TCK_HALF = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [1:0]        i_cmd_op,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic [DATA_W-1:0] i_cmd_data,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_err,
   output logic              o_tck,
   output logic              o_tms,
   output logic              o_tdi,
   input  logic              i_tdo
);
   localparam int IDX_W = $clog2(DATA_W);

   state_e             r_state;
   op_e                r_op;
   logic [LEN_W-1:0]   r_len;
   logic [DATA_W-1:0]  r_data;
   logic [LEN_W-1:0]   r_slot;
   logic               r_boot;

   logic               w_busy;
   logic               w_fall;
   logic               w_rise;
   logic               w_len_bad;
   logic [LEN_W-1:0]   w_nslots;
   state_e             w_after;
   state_e             w_ns;
   logic [LEN_W-1:0]   w_nslot;
   logic               w_tms;
   logic               w_tdi;

   assign w_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_len_bad = (i_cmd_len == '0) || (i_cmd_len > LEN_W'(DATA_W));

   jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (w_busy),
      .o_tck      (o_tck),
      .o_fall_stb (w_fall),
      .o_rise_stb (w_rise)
   );

   // State changes happen at fall strobes so the next state's first TMS/TDI is set up before its rise.
   always_comb begin
      w_nslots = '0;
      w_after  = S_DONE;
      case (r_state)
         S_AUTO_TLR: begin
            w_nslots = LEN_W'(TLR_SLOTS);
            w_after  = r_boot ? S_IDLE : S_DONE;
         end
         S_PRE: begin
            w_nslots = (r_op == OP_SHIFT_IR) ? LEN_W'(PRE_IR_SLOTS) : LEN_W'(PRE_DR_SLOTS);
            w_after  = S_SHIFT;
         end
         S_SHIFT: begin
            w_nslots = r_len;
            w_after  = S_POST;
         end
         S_POST:  w_nslots = LEN_W'(POST_SLOTS);
         S_RUN:   w_nslots = r_len;
         default: ;
      endcase
      w_ns    = (r_slot == w_nslots) ? w_after : r_state;
      w_nslot = (r_slot == w_nslots) ? '0 : r_slot;
      w_tms   = 1'b0;
      case (w_ns)
         S_AUTO_TLR: w_tms = TLR_TMS[w_nslot[2:0]];
         S_PRE:      w_tms = (r_op == OP_SHIFT_IR) ? PRE_IR_TMS[w_nslot[1:0]] : PRE_DR_TMS[w_nslot[1:0]];
         S_SHIFT:    w_tms = (w_nslot == r_len - LEN_W'(1));
         S_POST:     w_tms = (w_nslot == '0);
         default:    w_tms = 1'b0;
      endcase
      w_tdi = (w_ns == S_SHIFT) ? r_data[w_nslot[IDX_W-1:0]] : 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_AUTO_TLR;
         r_op        <= OP_RESET;
         r_len       <= '0;
         r_data      <= '0;
         r_slot      <= '0;
         r_boot      <= 1'b1;
         o_cmd_ready <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= '0;
         o_rsp_err   <= 1'b0;
         o_tms       <= 1'b1;
         o_tdi       <= 1'b0;
      end else begin
         o_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid && o_cmd_ready) begin
                  o_cmd_ready <= 1'b0;
                  r_op        <= op_e'(i_cmd_op);
                  r_len       <= i_cmd_len;
                  r_data      <= i_cmd_data;
                  r_slot      <= '0;
                  r_boot      <= 1'b0;
                  o_rsp_data  <= '0;
                  o_rsp_err   <= 1'b0;
                  case (op_e'(i_cmd_op))
                     OP_RESET: r_state <= S_AUTO_TLR;
                     OP_IDLE: begin
                        if (i_cmd_len == '0) begin
                           r_state     <= S_DONE;
                           o_rsp_valid <= 1'b1;
                        end else begin
                           r_state <= S_RUN;
                        end
                     end
                     default: begin
                        if (w_len_bad) begin
                           r_state     <= S_DONE;
                           o_rsp_valid <= 1'b1;
                           o_rsp_err   <= 1'b1;
                        end else begin
                           r_state <= S_PRE;
                        end
                     end
                  endcase
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               o_cmd_ready <= 1'b1;
            end
            default: begin
               if (w_fall) begin
                  r_state <= w_ns;
                  r_slot  <= w_nslot;
                  o_tms   <= w_tms;
                  o_tdi   <= w_tdi;
                  if (w_ns == S_DONE) o_rsp_valid <= 1'b1;
                  if (w_ns == S_IDLE) o_cmd_ready <= 1'b1;
               end else if (w_rise) begin
                  r_slot <= r_slot + LEN_W'(1);
                  if (r_state == S_SHIFT) o_rsp_data[r_slot[IDX_W-1:0]] <= i_tdo;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - self-checking bench for jtag_host with a TAP model and per-slot TMS/TDI scoreboard.
module tb_jtag_host;
   typedef enum int {
      TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
   } tap_e;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [6:0]  cmd_len = 7'd0;
   logic [63:0] cmd_data = 64'd0;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic        tck, tms, tdi;
   logic        tdo = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          rise_cnt = 0;
   int          rsp_cnt = 0;
   logic        loop_mode = 1'b0;
   logic        loop_q = 1'b0;
   logic [1:0]  exp_q[$];
   tap_e        tap = SHDR;
   logic [31:0] dr = 32'd0;
   logic [3:0]  irs = 4'd0;
   logic [3:0]  ir = 4'd0;

   jtag_host #(.DATA_W(64), .LEN_W(7), .TCK_HALF(1)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_op    (cmd_op),
      .i_cmd_len   (cmd_len),
      .i_cmd_data  (cmd_data),
      .o_rsp_valid (rsp_valid),
      .o_rsp_data  (rsp_data),
      .o_rsp_err   (rsp_err),
      .o_tck       (tck),
      .o_tms       (tms),
      .o_tdi       (tdi),
      .i_tdo       (tdo)
   );

   always #5 clk = ~clk;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PADR;
         PADR:  return m ? EX2DR : PADR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR:  return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PAIR;
         PAIR:  return m ? EX2IR : PAIR;
         EX2IR: return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   // Every TCK rise: compare TMS/TDI with the expected slot, then advance the TAP model.
   always @(posedge tck) begin
      logic [1:0] e;
      rise_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL tck_unexpected_rise actual_tms_tdi=%b%b required=no_rise", tms, tdi);
      end else begin
         e = exp_q.pop_front();
         if ({tms, tdi} !== e) begin
            n_fail++;
            $display("FAIL slot_tms_tdi actual=%b%b required=%b", tms, tdi, e);
         end
      end
      case (tap)
         CAPDR:   dr = 32'h1000_0001;
         SHDR:    dr = {tdi, dr[31:1]};
         CAPIR:   irs = 4'b0001;
         SHIR:    irs = {tdi, irs[3:1]};
         UPIR:    ir = irs;
         default: ;
      endcase
      loop_q = tdi;
      tap = tap_next(tap, tms);
   end

   always @(negedge tck)
      tdo = loop_mode ? loop_q : (tap == SHDR) ? dr[0] : (tap == SHIR) ? irs[0] : 1'b0;

   always @(negedge clk)
      if (rsp_valid) rsp_cnt++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Expected slot sequence derived from the TAP walk each operation must perform.
   task automatic push_slots(input logic [1:0] op, input logic [6:0] len, input logic [63:0] d);
      int n = int'(len);
      if (op == 2'b00) begin
         for (int i = 0; i < 6; i++) exp_q.push_back({i < 5, 1'b0});
         return;
      end
      if (op == 2'b11) begin
         for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
         return;
      end
      if (n == 0 || n > 64) return;
      if (op == 2'b01) exp_q.push_back(2'b10);
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, d[i]});
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
   endtask

   task automatic wait_ready(input string nm);
      int cyc = 0;
      while (!cmd_ready && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   task automatic run_cmd(input string nm, input logic [1:0] op, input logic [6:0] len,
                          input logic [63:0] d, input logic [63:0] exp_data,
                          input logic exp_err, input int exp_slots);
      int base_rise;
      int base_rsp;
      int cyc;
      wait_ready(nm);
      push_slots(op, len, d);
      base_rise = rise_cnt;
      base_rsp  = rsp_cnt;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      cmd_data  = d;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk({nm, "_ready_drop"}, 64'(cmd_ready), 64'd0);
      if (exp_slots == 0) chk({nm, "_rsp_next_clk"}, 64'(rsp_valid), 64'd1);
      cyc = 0;
      while (!rsp_valid && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_rsp_data"}, rsp_data, exp_data);
      chk({nm, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
      chk({nm, "_slots"}, 64'(rise_cnt - base_rise), 64'(exp_slots));
      chk({nm, "_slots_left"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_tap_rti"}, 64'(tap), 64'(RTI));
      chk({nm, "_tck_low"}, 64'(tck), 64'd0);
      @(posedge clk);
      #1;
      chk({nm, "_rsp_pulse_end"}, 64'(rsp_valid), 64'd0);
      chk({nm, "_rsp_count"}, 64'(rsp_cnt - base_rsp), 64'd1);
      chk({nm, "_rsp_data_hold"}, rsp_data, exp_data);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int base_rise;
      int base_rsp;
      int cyc;

      repeat (3) @(negedge clk);
      chk("rst_tck", 64'(tck), 64'd0);
      chk("rst_tms", 64'(tms), 64'd1);
      chk("rst_tdi", 64'(tdi), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);

      push_slots(2'b00, 7'd0, 64'd0);
      base_rise = rise_cnt;
      rst = 1'b0;
      wait_ready("boot");
      chk("boot_slots", 64'(rise_cnt - base_rise), 64'd6);
      chk("boot_tap_rti", 64'(tap), 64'(RTI));
      chk("boot_tck_low", 64'(tck), 64'd0);
      chk("boot_slots_left", 64'(exp_q.size()), 64'd0);

      run_cmd("ir_idcode", 2'b01, 7'd4, 64'h2, 64'h1, 1'b0, 10);
      chk("ir_loaded", 64'(ir), 64'h2);
      run_cmd("dr_idcode", 2'b10, 7'd32, 64'h0, 64'h1000_0001, 1'b0, 37);

      loop_mode = 1'b1;
      run_cmd("bypass_a5", 2'b10, 7'd8, 64'hA5, 64'h4A, 1'b0, 13);
      run_cmd("bypass_64", 2'b10, 7'd64, 64'hDEAD_BEEF_0123_4567,
              64'hBD5B_7DDE_0246_8ACE, 1'b0, 69);
      loop_mode = 1'b0;

      run_cmd("err_len0", 2'b10, 7'd0, 64'hFF, 64'h0, 1'b1, 0);
      run_cmd("idle_100", 2'b11, 7'd100, 64'h0, 64'h0, 1'b0, 100);
      run_cmd("err_len65", 2'b01, 7'd65, 64'h3, 64'h0, 1'b1, 0);
      run_cmd("idle_0", 2'b11, 7'd0, 64'h0, 64'h0, 1'b0, 0);
      run_cmd("op_reset", 2'b00, 7'd0, 64'h0, 64'h0, 1'b0, 6);

      wait_ready("mid");
      push_slots(2'b10, 7'd32, 64'h0);
      base_rise = rise_cnt;
      base_rsp  = rsp_cnt;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_len   = 7'd32;
      cmd_data  = 64'h0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cyc = 0;
      while ((rise_cnt - base_rise) < 10 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_reach_slot10", 64'(rise_cnt - base_rise), 64'd10);
      rst = 1'b1;
      #1;
      chk("mid_rst_tck", 64'(tck), 64'd0);
      chk("mid_rst_tms", 64'(tms), 64'd1);
      chk("mid_rst_tdi", 64'(tdi), 64'd0);
      chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      exp_q.delete();
      push_slots(2'b00, 7'd0, 64'd0);
      repeat (3) @(negedge clk);
      base_rise = rise_cnt;
      rst = 1'b0;
      wait_ready("mid_reboot");
      chk("mid_reboot_slots", 64'(rise_cnt - base_rise), 64'd6);
      chk("mid_reboot_tap_rti", 64'(tap), 64'(RTI));
      chk("mid_no_rsp", 64'(rsp_cnt - base_rsp), 64'd0);
      chk("mid_slots_left", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
